// File: rtl/mac_result_fifo.sv
// Result FIFO sitting behind the sum-of-squares accumulator.
// Buffers accumulator results with a wrap tag that flags a result smaller than the
// previous one. The head is registered, so a push shows up on the next cycle. Results
// that arrive while the FIFO is full are dropped and counted.
module mac_result_fifo #(
  parameter int unsigned DEPTH = 8,  // power of two, 2..16
  parameter int unsigned WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         f_in,
  input  logic                     valid_in,
  input  logic                     ready_in,
  output logic [WIDTH-1:0]         dout,
  output logic                     wrap_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Each entry is {wrap, result}; storage is deliberately left unreset.
  logic [WIDTH:0]    mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        drop_q, drop_d;
  logic [WIDTH-1:0]  last_q, last_d;

  logic full, empty, push, pop, drop, wrap_tag;

  // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO can still
  // accept a push when the head is being consumed.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    pop      = !empty && ready_in;
    push     = valid_in && (!full || pop);
    drop     = valid_in && full && !pop;
    wrap_tag = (f_in < last_q);
  end

  // Next-state for pointers, occupancy, drop counter and last-seen result.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    last_d   = last_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    // last_f tracks every offered result, accepted or dropped.
    if (valid_in) last_d = f_in;
  end

  // Control state register with synchronous reset; reset discards buffered entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      last_q   <= last_d;
    end
  end

  // Storage write; suppressed during reset so a reset cycle never leaves a stray entry.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {wrap_tag, f_in};
  end

  // Head presentation; gated to zero when empty so reset shows dout=0, wrap_out=0.
  always_comb begin
    valid_out = !empty;
    dout      = '0;
    wrap_out  = 1'b0;
    if (!empty) begin
      dout     = mem_q[rd_ptr_q][WIDTH-1:0];
      wrap_out = mem_q[rd_ptr_q][WIDTH];
    end
    count    = count_q;
    drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_mac_result_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  f_in;
  logic              valid_in;
  logic              ready_in;
  logic [WIDTH-1:0]  dout;
  logic              wrap_out;
  logic              valid_out;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]        drop_cnt;

  mac_result_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .f_in     (f_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .dout     (dout),
    .wrap_out (wrap_out),
    .valid_out(valid_out),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {wrap, value}, last offered value, drop count.
  logic [WIDTH:0]   mq[$];
  logic [WIDTH-1:0] m_last;
  int unsigned      m_drop;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 after the edge.
  task automatic step(input logic rst, input logic vin, input logic [WIDTH-1:0] f,
                      input logic rdy);
    logic [WIDTH:0] junk;
    logic           m_pop;
    logic           m_can;
    reset    = rst;
    valid_in = vin;
    f_in     = f;
    ready_in = rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_last = '0;
      m_drop = 0;
    end else begin
      m_pop = (mq.size() != 0) && rdy;
      m_can = (mq.size() < DEPTH) || m_pop;
      if (m_pop) junk = mq.pop_front();
      if (vin) begin
        if (m_can) mq.push_back({(f < m_last), f});
        else if (m_drop < 255) m_drop++;
        m_last = f;
      end
    end
    #1;
    check("count", 32'(count), mq.size());
    check("valid_out", 32'(valid_out), 32'(mq.size() != 0));
    check("drop_cnt", 32'(drop_cnt), m_drop);
    if (mq.size() != 0) begin
      check("dout", 32'(dout), 32'(mq[0][WIDTH-1:0]));
      check("wrap_out", 32'(wrap_out), 32'(mq[0][WIDTH]));
    end
    if (rst) begin
      check("rst_dout", 32'(dout), 0);
      check("rst_wrap", 32'(wrap_out), 0);
    end
  endtask

  initial begin
    logic [7:0] drop_before;
    logic       rdy;
    mq.delete();
    m_last = '0;
    m_drop = 0;
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; f_in = '0;

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 20'd7, 1'b1);  // reset wins over a push

    // Basic ordering: first push visible on the next cycle, then streams through.
    step(1'b0, 1'b1, 20'd441, 1'b1);
    check("basic_first", 32'(dout), 441);
    step(1'b0, 1'b1, 20'd1737, 1'b1);
    check("basic_second", 32'(dout), 1737);
    check("basic_wrap", 32'(wrap_out), 0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("basic_empty", 32'(count), 0);

    // Backpressure: 9 pushes into 8 slots, one drop, then drain in order.
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b0);
    check("full_count", 32'(count), 8);
    check("full_drop", 32'(drop_cnt), 1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 32'(dout), i);
      step(1'b0, 1'b0, '0, 1'b1);
    end

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, WIDTH'(200 + i), 1'b0);
    drop_before = drop_cnt;
    step(1'b0, 1'b1, 20'd100, 1'b1);
    check("fullpp_count", 32'(count), 8);
    check("fullpp_drop", 32'(drop_cnt), 32'(drop_before));
    check("fullpp_head", 32'(dout), 201);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Wrap tag, including a dropped value feeding the next compare.
    step(1'b0, 1'b1, 20'd1048000, 1'b0);
    step(1'b0, 1'b1, 20'd1500, 1'b0);
    check("wrap_first", 32'(wrap_out), 0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("wrap_second", 32'(wrap_out), 1);
    check("wrap_second_val", 32'(dout), 1500);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, WIDTH'(10 + i), 1'b0);
    step(1'b0, 1'b1, 20'd50000, 1'b0);      // dropped, still updates last_f
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 20'd40000, 1'b0);      // 40000 < 50000 -> wrap
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-operation.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, WIDTH'(3000 + i), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("midrst_count", 32'(count), 0);
    check("midrst_valid", 32'(valid_out), 0);
    check("midrst_drop", 32'(drop_cnt), 0);
    step(1'b0, 1'b1, 20'd5833, 1'b0);
    check("midrst_push", 32'(dout), 5833);
    check("midrst_wrap", 32'(wrap_out), 0);

    // Drop counter saturation.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
    check("sat_drop", 32'(drop_cnt), 255);
    step(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
    check("sat_hold", 32'(drop_cnt), 255);

    // Random traffic with phased consumer bias and occasional resets.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       rdy = ($urandom_range(0, 3) == 0);
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = $urandom_range(0, 1) != 0;
      endcase
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
           ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 63)) : WIDTH'($urandom),
           rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
